// File: rtl/candidate_scheduler_if.sv
// Handshake bundle between a candidate-list producer and the scheduler, plus the
// mapping-entry stream toward the consumer.
interface candidate_scheduler_if #(
   parameter int unsigned BS = 16
);
   localparam int unsigned IW = $clog2(BS);

   logic          list_valid;
   logic          list_ready;
   logic [0:BS-1] candidate_list;
   logic          map_valid;
   logic          map_ready;
   logic [IW-1:0] map_idx;
   logic [IW-1:0] map_slot;
   logic          map_last;
   logic          done;
   logic [IW:0]   total;

   modport master (
      output list_valid, candidate_list, map_ready,
      input  list_ready, map_valid, map_idx, map_slot, map_last, done, total
   );

   modport slave (
      input  list_valid, candidate_list, map_ready,
      output list_ready, map_valid, map_idx, map_slot, map_last, done, total
   );
endinterface

// File: rtl/candidate_scheduler.sv
// Compacts a sparse candidate bitmap into a dense slot table: emits (index, slot) pairs
// in ascending index order, then pulses done and publishes the candidate count.
module candidate_scheduler #(
   parameter int unsigned BS = 16
) (
   input logic                    clk,
   input logic                    rst,
   candidate_scheduler_if.slave   bus
);
   localparam int unsigned IW = $clog2(BS);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e        r_state, w_state_d;
   logic [0:BS-1] r_pending, w_pending_d, w_pending_clr;
   logic [IW:0]   r_slot, w_slot_d;
   logic [IW:0]   r_total, w_total_d;
   logic [IW-1:0] w_low_idx;
   logic          w_last;

   // Lowest set pending bit; scanning downward lets the lowest index win.
   always_comb begin
      w_low_idx = '0;
      for (int i = BS - 1; i >= 0; i--) begin
         if (r_pending[i]) w_low_idx = IW'(i);
      end
      w_pending_clr            = r_pending;
      w_pending_clr[w_low_idx] = 1'b0;
      w_last                   = (w_pending_clr == '0);
   end

   always_comb begin
      w_state_d          = r_state;
      w_pending_d        = r_pending;
      w_slot_d           = r_slot;
      w_total_d          = r_total;
      bus.list_ready     = 1'b0;
      bus.map_valid      = 1'b0;
      bus.map_idx        = '0;
      bus.map_slot       = '0;
      bus.map_last       = 1'b0;
      bus.done           = 1'b0;
      unique case (r_state)
         StIdle: begin
            bus.list_ready = 1'b1;
            if (bus.list_valid) begin
               w_pending_d = bus.candidate_list;
               w_slot_d    = '0;
               w_state_d   = (bus.candidate_list == '0) ? StDone : StScan;
            end
         end
         StScan: begin
            bus.map_valid = 1'b1;
            bus.map_idx   = w_low_idx;
            bus.map_slot  = r_slot[IW-1:0];
            bus.map_last  = w_last;
            if (bus.map_ready) begin
               w_pending_d = w_pending_clr;
               w_slot_d    = r_slot + (IW+1)'(1);
               if (w_last) w_state_d = StDone;
            end
         end
         StDone: begin
            bus.done  = 1'b1;
            w_total_d = r_slot;
            w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign bus.total = r_total;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_pending <= '0;
         r_slot    <= '0;
         r_total   <= '0;
      end else begin
         r_state   <= w_state_d;
         r_pending <= w_pending_d;
         r_slot    <= w_slot_d;
         r_total   <= w_total_d;
      end
   end
endmodule

// File: tb/tb_candidate_scheduler.sv
// Self-checking bench for candidate_scheduler: directed vector table, reset-mid-scan
// sequence and randomized lists against a cycle-level reference of the list rules.
module tb_candidate_scheduler;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   candidate_scheduler_if #(.BS(16)) bus ();

   candidate_scheduler #(.BS(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [0:15] lst;
      int          mode;       // 0: ready always, 1: random ready + noise, 2: stall first entry
      int          exp_total;
      int          exp_last;   // index carried by map_last, -1 if none
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the list is an ordered set of indices; entry k carries the k-th lowest
   // index and slot k, the stream ends with one done cycle, then IDLE with total = count.
   task automatic run_list(input logic [0:15] lst, input int mode, output int last_seen);
      int   exp_idx[$];
      int   ptr;
      int   cyc;
      logic rdy;
      exp_idx = {};
      for (int i = 0; i < 16; i++) if (lst[i]) exp_idx.push_back(i);
      last_seen = -1;
      cyc = 0;
      while (!bus.list_ready && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("list_ready_before_accept", bus.list_ready, 1);
      bus.candidate_list = lst;
      bus.list_valid     = 1'b1;
      bus.map_ready      = 1'b0;
      tick();
      bus.list_valid = 1'b0;
      ptr = 0;
      cyc = 0;
      while (ptr < exp_idx.size() && cyc < 200) begin
         chk("scan_map_valid", bus.map_valid, 1);
         chk("scan_map_idx", bus.map_idx, exp_idx[ptr]);
         chk("scan_map_slot", bus.map_slot, ptr);
         chk("scan_map_last", bus.map_last, (ptr == exp_idx.size() - 1) ? 1 : 0);
         chk("scan_list_ready", bus.list_ready, 0);
         chk("scan_done", bus.done, 0);
         if (bus.map_valid && bus.map_last) last_seen = int'(bus.map_idx);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (cyc >= 3);
         endcase
         if (mode != 0) begin
            bus.list_valid     = 1'($urandom_range(0, 1));
            bus.candidate_list = 16'($urandom);
         end
         bus.map_ready = rdy;
         tick();
         cyc++;
         if (rdy) ptr++;
      end
      if (cyc >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL scan_timeout: consumed %0d, expected %0d entries", ptr, exp_idx.size());
      end
      bus.map_ready = 1'b0;
      chk("done_pulse", bus.done, 1);
      chk("done_map_valid", bus.map_valid, 0);
      chk("done_list_ready", bus.list_ready, 0);
      tick();
      bus.list_valid = 1'b0;
      chk("after_done_pulse", bus.done, 0);
      chk("after_done_list_ready", bus.list_ready, 1);
      chk("after_done_total", bus.total, exp_idx.size());
   endtask

   initial begin
      int last;
      int cnt;
      logic [0:15] rl;
      n_checks = 0;
      n_errors = 0;

      tbl[0] = '{"bits_3_7_12",   16'b0001_0001_0000_1000, 0, 3, 12};
      tbl[1] = '{"all_ones",      16'hFFFF,                0, 16, 15};
      tbl[2] = '{"empty",         16'h0000,                0, 0, -1};
      tbl[3] = '{"bits_0_15_stall", 16'b1000_0000_0000_0001, 2, 2, 15};
      tbl[4] = '{"single_5",      16'b0000_0100_0000_0000, 1, 1, 5};
      tbl[5] = '{"noise_3_7_12",  16'b0001_0001_0000_1000, 1, 3, 12};

      rst                = 1'b1;
      bus.list_valid     = 1'b0;
      bus.candidate_list = '0;
      bus.map_ready      = 1'b0;
      #1;
      chk("reset_list_ready", bus.list_ready, 1);
      chk("reset_map_valid", bus.map_valid, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_total", bus.total, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      for (int v = 0; v < 6; v++) begin
         run_list(tbl[v].lst, tbl[v].mode, last);
         chk({tbl[v].name, "_total"}, bus.total, tbl[v].exp_total);
         chk({tbl[v].name, "_last_idx"}, last, tbl[v].exp_last);
         tick();
         tick();
         chk({tbl[v].name, "_total_hold"}, bus.total, tbl[v].exp_total);
      end

      // Reset after two entries of a five-candidate list {1,4,6,9,13}.
      bus.candidate_list = 16'b0100_1010_0100_0100;
      bus.list_valid     = 1'b1;
      tick();
      bus.list_valid = 1'b0;
      bus.map_ready  = 1'b1;
      chk("rst_seq_e0_idx", bus.map_idx, 1);
      tick();
      chk("rst_seq_e1_idx", bus.map_idx, 4);
      chk("rst_seq_e1_slot", bus.map_slot, 1);
      tick();
      chk("rst_seq_e2_idx", bus.map_idx, 6);
      rst = 1'b1;
      #1;
      bus.map_ready = 1'b0;
      chk("rst_mid_list_ready", bus.list_ready, 1);
      chk("rst_mid_map_valid", bus.map_valid, 0);
      chk("rst_mid_map_idx", bus.map_idx, 0);
      chk("rst_mid_total", bus.total, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_hold_done", bus.done, 0);
         chk("rst_hold_map_valid", bus.map_valid, 0);
      end
      rst = 1'b0;
      tick();
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_total", bus.total, 0);
      run_list(tbl[0].lst, 0, last);
      chk("post_rst_list_total", bus.total, 3);

      for (int r = 0; r < 40; r++) begin
         case ($urandom_range(0, 9))
            0:       rl = 16'h0000;
            1:       rl = 16'hFFFF;
            default: rl = 16'($urandom);
         endcase
         cnt = 0;
         for (int i = 0; i < 16; i++) if (rl[i]) cnt++;
         run_list(rl, 1, last);
         chk("rand_total", bus.total, cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
